// File: rtl/spi_xip_reader.sv
// SPI flash XIP reader: fast-read in single, dual-output or quad-output mode.
// Define SPI_XIP_BURST_EN to hold ss low and chain sequential reads.
module spi_xip_reader #(
    parameter int ADDR_BYTES   = 3,
    parameter int RSP_BYTES    = 4,
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 8,
    parameter int SS_WIDTH     = 1,
    localparam int SEL_W = (SS_WIDTH > 1) ? $clog2(SS_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_xip_cmd_valid,
    output logic                    io_xip_cmd_ready,
    input  logic [8*ADDR_BYTES-1:0] io_xip_cmd_payload,
    input  logic [SEL_W-1:0]        io_ssSel,
    input  logic [1:0]              io_mode,
    output logic                    io_xip_rsp_valid,
    output logic [8*RSP_BYTES-1:0]  io_xip_rsp_payload,
    output logic                    io_spi_sclk,
    output logic [SS_WIDTH-1:0]     io_spi_ss,
    output logic [3:0]              io_spi_data_write,
    output logic [3:0]              io_spi_data_writeEnable,
    input  logic [3:0]              io_spi_data_read
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int RW = 8 * RSP_BYTES;
    localparam int TW = AW + 8;
    localparam logic [15:0] HALF_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0] DESEL_END = 16'(2 * CLK_DIV - 1);
    localparam logic [7:0]  ADDR_BITS  = 8'(AW);
    localparam logic [7:0]  DUMMY_BITS = 8'(DUMMY_CYCLES);
    localparam logic [7:0]  DATA_BITS  = 8'(RW);
`ifdef SPI_XIP_BURST_EN
    localparam logic [15:0] HOLD_END  = 16'd255;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESELECT
`ifdef SPI_XIP_BURST_EN
        , S_HOLD
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              half_q, half_d;
    logic [7:0]        bits_q, bits_d;
    logic [TW-1:0]     tx_q, tx_d;
    logic [RW-1:0]     rx_q, rx_d;
    logic [1:0]        mode_q, mode_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              pend_q, pend_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]     payload_q, payload_d;
`ifdef SPI_XIP_BURST_EN
    logic [AW-1:0]     addr_q, addr_d;
    logic              burst_hit;
`endif

    logic              accept, bit_end, active;
    logic [1:0]        mode_in;
    logic [SEL_W-1:0]  sel_in;
    logic [7:0]        opcode;
    logic [RW-1:0]     rx_shift, rx_swap;

    assign accept  = io_xip_cmd_valid && io_xip_cmd_ready;
    assign bit_end = half_q && (cnt_q == HALF_END);

    always_comb begin
        mode_in = (io_mode == 2'd3) ? 2'd0 : io_mode;
        sel_in  = (32'(io_ssSel) < 32'(SS_WIDTH)) ? io_ssSel : '0;
        unique case (mode_in)
            2'd1:    opcode = 8'h3B;
            2'd2:    opcode = 8'h6B;
            default: opcode = 8'h0B;
        endcase
    end

    // Lane 1 carries MSB in dual mode, lane 3 in quad mode.
    always_comb begin
        unique case (mode_q)
            2'd1:    rx_shift = {rx_q[RW-3:0], io_spi_data_read[1:0]};
            2'd2:    rx_shift = {rx_q[RW-5:0], io_spi_data_read};
            default: rx_shift = {rx_q[RW-2:0], io_spi_data_read[1]};
        endcase
        for (int k = 0; k < RSP_BYTES; k++) begin
            rx_swap[8*k +: 8] = rx_shift[RW-8-8*k +: 8];
        end
    end

`ifdef SPI_XIP_BURST_EN
    assign burst_hit = (mode_in == mode_q) && (sel_in == sel_q) &&
                       (io_xip_cmd_payload == addr_q + AW'(RSP_BYTES));
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        bits_d      = bits_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        rsp_valid_d = 1'b0;
        payload_d   = payload_q;
`ifdef SPI_XIP_BURST_EN
        addr_d      = addr_q;
        if (accept) addr_d = io_xip_cmd_payload;
`endif
        if (accept) begin
            mode_d = mode_in;
            sel_d  = sel_in;
            tx_d   = {opcode, io_xip_cmd_payload};
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SELECT;
                    cnt_d   = '0;
                end
            end
            S_SELECT: begin
                if (cnt_q == HALF_END) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bits_d  = 8'd8;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (cnt_q == HALF_END) begin
                    cnt_d  = '0;
                    half_d = !half_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (bit_end) begin
                    bits_d = bits_q - 8'd1;
                    if (state_q == S_DATA) rx_d = rx_shift;
                    else tx_d = tx_q << 1;
                    if (bits_q == 8'd1) begin
                        if (state_q == S_CMD) begin
                            state_d = S_ADDR;
                            bits_d  = ADDR_BITS;
                        end else if (state_q == S_ADDR && DUMMY_CYCLES > 0) begin
                            state_d = S_DUMMY;
                            bits_d  = DUMMY_BITS;
                        end else if (state_q != S_DATA) begin
                            state_d = S_DATA;
                            bits_d  = DATA_BITS >> mode_q;
                        end else begin
                            rsp_valid_d = 1'b1;
                            payload_d   = rx_swap;
`ifdef SPI_XIP_BURST_EN
                            state_d     = S_HOLD;
`else
                            state_d     = S_DESELECT;
`endif
                        end
                    end
                end
            end
            S_DESELECT: begin
                if (cnt_q == DESEL_END) begin
                    cnt_d   = '0;
                    state_d = pend_q ? S_SELECT : S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SPI_XIP_BURST_EN
            S_HOLD: begin
                if (accept && burst_hit) begin
                    state_d = S_DATA;
                    bits_d  = DATA_BITS >> mode_in;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                end else if (accept) begin
                    state_d = S_DESELECT;
                    pend_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_END) begin
                    state_d = S_DESELECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            bits_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            mode_q      <= '0;
            sel_q       <= '0;
            pend_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            payload_q   <= '0;
`ifdef SPI_XIP_BURST_EN
            addr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            bits_q      <= bits_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            payload_q   <= payload_d;
`ifdef SPI_XIP_BURST_EN
            addr_q      <= addr_d;
`endif
        end
    end

    always_comb begin
        active = (state_q == S_SELECT) || (state_q == S_CMD) ||
                 (state_q == S_ADDR) || (state_q == S_DUMMY) ||
                 (state_q == S_DATA);
        io_xip_cmd_ready = !reset && (state_q == S_IDLE);
`ifdef SPI_XIP_BURST_EN
        active = active || (state_q == S_HOLD);
        io_xip_cmd_ready = !reset && ((state_q == S_IDLE) || (state_q == S_HOLD));
`endif
        io_spi_ss = active ? ~(SS_WIDTH'(1) << sel_q) : '1;
        io_spi_data_writeEnable = ((state_q == S_CMD) || (state_q == S_ADDR)) ?
                                  4'b0001 : 4'b0000;
        io_spi_data_write = {3'b000, tx_q[TW-1] & io_spi_data_writeEnable[0]};
    end

    assign io_spi_sclk        = half_q;
    assign io_xip_rsp_valid   = rsp_valid_q;
    assign io_xip_rsp_payload = payload_q;
endmodule
